reg_arr_sched: RTL
==================

REG_ARR_SCHED -- requirements
Module: reg_arr_sched

Interface
REQ-001 SHALL have parameter ROWS, default 12, array row count.
REQ-002 SHALL have parameter COLS, default 12, array column count.
REQ-003 SHALL have parameter DW, default 36, data width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports pN_valid  in  1  request valid, N=0,1.
REQ-007 SHALL have ports pN_ready  out  1  request accepted this cycle.
REQ-008 SHALL have ports pN_we  in  1  1=write, 0=read.
REQ-009 SHALL have ports pN_row, pN_col  in  4 each  target address.
REQ-010 SHALL have ports pN_wdata  in  DW  write data.
REQ-011 SHALL have ports pN_rvalid  out  1  read response valid.
REQ-012 SHALL have ports pN_rdata  out  DW  read response data.
REQ-013 SHALL have port clr_req  in  1  pulse, start full-array clear.
REQ-014 SHALL have port busy  out  1  clear sweep in progress.
REQ-015 SHALL have port err  out  1  one-cycle pulse, rejected request.
REQ-016 SHALL have ports arr_addr_row, arr_addr_col  out  4 each  array address.
REQ-017 SHALL have ports arr_write_en, arr_read_en  out  1 each  array strobes.
REQ-018 SHALL have port arr_data_in  out  DW  array write data.
REQ-019 SHALL have port arr_data_out  in  DW  registered array read data.

Function
REQ-020 SHALL accept a request on pN_valid && pN_ready (handshake at that edge, cycle T).
REQ-021 SHALL assert at most one pN_ready per cycle; both 0 while busy.
REQ-022 SHALL arbitrate round-robin: both valid -> grant port not granted last; single valid -> grant it, no bubble.
REQ-023 SHALL drive registered arr_* signals for exactly cycle T+1 per accepted request; arr_write_en and arr_read_en never both 1.
REQ-024 SHALL, for a read accepted at T, assert pN_rvalid to the requesting port only in cycle T+2 with pN_rdata = arr_data_out; otherwise pN_rvalid=0, pN_rdata=0.
REQ-025 SHALL sustain one request per cycle; back-to-back reads yield back-to-back rvalid.
REQ-026 SHALL give read-after-write to the same address the new data (write at T, read at T+1 returns it at T+3).
REQ-027 SHALL run FSM IDLE/SERVE/CLEAR: IDLE->SERVE on any valid; SERVE->IDLE when no valid; any->CLEAR on clr_req at cycle end; CLEAR->IDLE after last entry.
REQ-028 SHALL in CLEAR write zero to all ROWS*COLS entries, row-major, one per cycle, from (0,0) to (ROWS-1,COLS-1); busy=1 from cycle after clr_req through the last write cycle.
REQ-029 SHALL let an already accepted read complete its rvalid during CLEAR; clr_req while busy is ignored.
REQ-030 SHALL, on clr_req and pN_valid in the same cycle, grant neither port.

Reset
REQ-031 SHALL on rst_n=0 immediately clear: FSM=IDLE, RR pointer favours port 0, all pN_ready/pN_rvalid/pN_rdata/busy/err/arr_* = 0.
REQ-032 SHALL abandon an in-flight clear or read on reset, issuing no response afterwards.

Configuration
REQ-033 SHALL with REG_ARR_SCHED_BOUNDS_CHECK_EN defined reject row>=ROWS or col>=COLS: handshake completes, no arr_* access, no rvalid, err pulses at T+1.
REQ-034 SHALL without the macro pass addresses unchecked; err tied 0.

Structure
REQ-035 SHALL place ROWS/COLS/DW defaults, state enum and request struct in package reg_arr_pkg.
REQ-036 SHALL implement arbitration in sub-module rr_arb2 (2-way round-robin, combinational grant, registered pointer).

Verification
REQ-037 p0 write (3,4)=0x123456789, next cycle p1 read (3,4) -> p1_rvalid two cycles after handshake, p1_rdata=0x123456789.
REQ-038 p0,p1 both valid reads for 4 cycles -> grants alternate 0,1,0,1 starting port 0 after reset.
REQ-039 Fill all entries nonzero, pulse clr_req -> busy high 144 cycles, 144 arr_write_en writes of 0, then every read returns 0.
REQ-040 Macro defined, p0 read (12,0) -> err pulse, no arr_read_en, no p0_rvalid; macro undefined -> err stays 0.
REQ-041 rst_n low mid-clear at entry (5,7) -> outputs 0 asynchronously, busy=0, no rvalid after release.
REQ-042 clr_req coincident with p1_valid -> p1_ready=0 until busy falls, then p1 granted.

Source files
------------

// File: rtl/reg_arr_pkg.sv
// Shared types and defaults for the register-array scheduler.
// Used by reg_arr_sched and rr_arb2.
package reg_arr_pkg;

  localparam int unsigned ROWS_DEF = 12;
  localparam int unsigned COLS_DEF = 12;
  localparam int unsigned DW_DEF   = 36;
  localparam int unsigned AW       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
  } req_t;

  function automatic logic in_bounds(input logic [AW-1:0] row, input logic [AW-1:0] col,
                                     input int unsigned rows, input int unsigned cols);
    return (32'(row) < rows) && (32'(col) < cols);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt_c
);

  // ptr_q = 0 favours port 0, 1 favours port 1
  logic ptr_q;

  always_comb begin
    gnt_c = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !ptr_q)) gnt_c = 2'b01;
      else if (req[1])                   gnt_c = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr_q <= 1'b0;
    else if (gnt_c[0]) ptr_q <= 1'b1;
    else if (gnt_c[1]) ptr_q <= 1'b0;
  end

endmodule

// File: rtl/reg_arr_sched.sv
// Two-port scheduler in front of a registered-read register array, with a full-array clear sweep.
// Optional address bounds checking: define REG_ARR_SCHED_BOUNDS_CHECK_EN.
module reg_arr_sched
  import reg_arr_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_row,
  input  logic [AW-1:0] p0_col,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_row,
  input  logic [AW-1:0] p1_col,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  input  logic          clr_req,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] arr_addr_row,
  output logic [AW-1:0] arr_addr_col,
  output logic          arr_write_en,
  output logic          arr_read_en,
  output logic [DW-1:0] arr_data_in,
  input  logic [DW-1:0] arr_data_out
);

  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
  localparam logic [AW-1:0] COL_LAST = AW'(COLS - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_c;
  logic          accept_en_c;
  logic          any_valid_c;
  logic          sweep_last_c;
  logic          addr_ok_c;
  req_t          sel_req_c;
  logic [DW-1:0] sel_wdata_c;

  logic [AW-1:0] row_d, col_d;
  logic [DW-1:0] din_d;
  logic          we_d, re_d, busy_d, err_d;
  logic          rd_port_q, rd_port_d;
  logic          p0_rvalid_d, p1_rvalid_d;

  // No grants during a sweep, in reset, or in the cycle a clear is requested
  assign accept_en_c = rst_n && (state_q != ST_CLEAR) && !clr_req;
  assign any_valid_c = p0_valid || p1_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({p1_valid, p0_valid}),
    .en    (accept_en_c),
    .gnt_c (gnt_c)
  );

  assign p0_ready = gnt_c[0];
  assign p1_ready = gnt_c[1];

  assign sel_req_c   = gnt_c[1] ? req_t'{we: p1_we, row: p1_row, col: p1_col}
                                : req_t'{we: p0_we, row: p0_row, col: p0_col};
  assign sel_wdata_c = gnt_c[1] ? p1_wdata : p0_wdata;

`ifdef REG_ARR_SCHED_BOUNDS_CHECK_EN
  assign addr_ok_c = in_bounds(sel_req_c.row, sel_req_c.col, ROWS, COLS);
`else
  assign addr_ok_c = 1'b1;
`endif

  // The array address registers double as the sweep position during CLEAR
  assign sweep_last_c = (arr_addr_row == ROW_LAST) && (arr_addr_col == COL_LAST);

  always_comb begin
    state_d     = state_q;
    row_d       = '0;
    col_d       = '0;
    din_d       = '0;
    we_d        = 1'b0;
    re_d        = 1'b0;
    err_d       = 1'b0;
    rd_port_d   = rd_port_q;
    p0_rvalid_d = arr_read_en && !rd_port_q;
    p1_rvalid_d = arr_read_en && rd_port_q;
    case (state_q)
      ST_CLEAR: begin
        if (sweep_last_c) begin
          state_d = ST_IDLE;
        end else begin
          we_d = 1'b1;
          if (arr_addr_col == COL_LAST) begin
            row_d = arr_addr_row + AW'(1);
            col_d = '0;
          end else begin
            row_d = arr_addr_row;
            col_d = arr_addr_col + AW'(1);
          end
        end
      end
      default: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          we_d    = 1'b1;
        end else begin
          state_d = any_valid_c ? ST_SERVE : ST_IDLE;
          if (|gnt_c) begin
            if (addr_ok_c) begin
              row_d     = sel_req_c.row;
              col_d     = sel_req_c.col;
              we_d      = sel_req_c.we;
              re_d      = !sel_req_c.we;
              din_d     = sel_req_c.we ? sel_wdata_c : '0;
              rd_port_d = gnt_c[1];
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      arr_addr_row <= '0;
      arr_addr_col <= '0;
      arr_write_en <= 1'b0;
      arr_read_en  <= 1'b0;
      arr_data_in  <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      rd_port_q    <= 1'b0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      arr_addr_row <= row_d;
      arr_addr_col <= col_d;
      arr_write_en <= we_d;
      arr_read_en  <= re_d;
      arr_data_in  <= din_d;
      busy         <= busy_d;
      err          <= err_d;
      rd_port_q    <= rd_port_d;
      p0_rvalid    <= p0_rvalid_d;
      p1_rvalid    <= p1_rvalid_d;
    end
  end

  // Array read data is already registered; steer it to the owning port only while valid
  assign p0_rdata = p0_rvalid ? arr_data_out : '0;
  assign p1_rdata = p1_rvalid ? arr_data_out : '0;

endmodule
